seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_scan_driver_if.sv | 24 ++
 rtl/seg7_scan_driver.sv | 158 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// Input/output bundle for the multiplexed 7-segment scan driver.
// The master drives the display request; the slave (the driver) returns select and segment lines.
interface seg7_scan_driver_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  enable;
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp_in;
    logic                  blank_lz;
    logic [DIGITS-1:0]     sel;
    logic [7:0]            data;
    logic                  frame_done;

    modport master (
        output enable, load, value, dp_in, blank_lz,
        input  sel, data, frame_done
    );

    modport slave (
        input  enable, load, value, dp_in, blank_lz,
        output sel, data, frame_done
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for an active-low common-anode 7-segment display.
// Loaded values are double-buffered so a frame is always drawn from one consistent value.
module seg7_scan_driver #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned HEX_EN   = 1
) (
    input  logic               clk,
    input  logic               rst,
    seg7_scan_driver_if.slave  bus
);

    localparam int unsigned    CntW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned    IdxW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);
    localparam logic [IdxW-1:0] IdxMax = IdxW'(DIGITS - 1);

    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0]   pend_val_q, pend_val_d;
    logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
    logic                  pend_flag_q, pend_flag_d;
    logic [4*DIGITS-1:0]   disp_val_q, disp_val_d;
    logic [DIGITS-1:0]     disp_dp_q, disp_dp_d;
    logic [DIGITS-1:0]     sel_q, sel_d;
    logic [7:0]            data_q, data_d;
    logic                  frame_done_q, frame_done_d;

    logic                  tick;
    logic                  wrap;
    logic [3:0]            nib;
    logic                  dp_bit;
    logic                  lead_zero;
    logic [6:0]            seg;
    logic [DIGITS-1:0]     onehot_n;

    // Scan timing and double buffering
    always_comb begin
        tick        = bus.enable && (cnt_q == CntMax);
        wrap        = tick && (idx_q == IdxMax);
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        pend_val_d  = pend_val_q;
        pend_dp_d   = pend_dp_q;
        pend_flag_d = pend_flag_q;
        disp_val_d  = disp_val_q;
        disp_dp_d   = disp_dp_q;

        if (bus.enable) begin
            if (tick) begin
                cnt_d = '0;
                idx_d = wrap ? '0 : idx_q + IdxW'(1);
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end

        if (wrap && pend_flag_q) begin
            disp_val_d  = pend_val_q;
            disp_dp_d   = pend_dp_q;
            pend_flag_d = 1'b0;
        end

        // A load coinciding with the wrap lands in the pending buffer for the next frame.
        if (bus.load) begin
            pend_val_d  = bus.value;
            pend_dp_d   = bus.dp_in;
            pend_flag_d = 1'b1;
        end
    end

    // Active-digit selection and leading-zero detection
    always_comb begin
        nib       = 4'h0;
        dp_bit    = 1'b0;
        lead_zero = 1'b1;
        onehot_n  = '1;
        for (int j = 0; j < int'(DIGITS); j++) begin
            if (IdxW'(j) == idx_q) begin
                nib         = disp_val_q[4*j +: 4];
                dp_bit      = disp_dp_q[j];
                onehot_n[j] = 1'b0;
            end
            if ((IdxW'(j) >= idx_q) && (disp_val_q[4*j +: 4] != 4'h0)) begin
                lead_zero = 1'b0;
            end
        end
    end

    // Segment decode, {a,b,c,d,e,f,g} active low
    always_comb begin
        case (nib)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        if ((HEX_EN == 0) && (nib > 4'h9)) begin
            seg = 7'b1111111;
        end
        if (bus.blank_lz && (idx_q != '0) && lead_zero) begin
            seg = 7'b1111111;
        end
    end

    always_comb begin
        sel_d        = '1;
        data_d       = 8'hFF;
        frame_done_d = wrap;
        if (bus.enable) begin
            sel_d  = onehot_n;
            data_d = {seg, ~dp_bit};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_flag_q  <= 1'b0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            sel_q        <= '1;
            data_q       <= 8'hFF;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_flag_q  <= pend_flag_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            sel_q        <= sel_d;
            data_q       <= data_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.sel        = sel_q;
    assign bus.data       = data_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: DIGITS=4, SCAN_DIV=4, one hex-enabled and one
// hex-disabled instance driven in lockstep.
module tb_seg7_scan_driver;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   cyc;
    int   last_fd;

    seg7_scan_driver_if #(.DIGITS(4)) bus ();
    seg7_scan_driver_if #(.DIGITS(4)) bus_nh ();

    assign bus_nh.enable   = bus.enable;
    assign bus_nh.load     = bus.load;
    assign bus_nh.value    = bus.value;
    assign bus_nh.dp_in    = bus.dp_in;
    assign bus_nh.blank_lz = bus.blank_lz;

    seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .HEX_EN(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .HEX_EN(0)) dut_nh (
        .clk (clk),
        .rst (rst),
        .bus (bus_nh.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        while ((bus.frame_done !== 1'b1) && (n < 100)) begin
            step();
            n++;
        end
        chk("frame_done_seen", {15'b0, bus.frame_done}, 16'd1);
    endtask

    task automatic chk_digit(input string tag, input logic [3:0] s, input logic [7:0] d);
        chk({tag, "_sel"}, {12'b0, bus.sel}, {12'b0, s});
        chk({tag, "_data"}, {8'b0, bus.data}, {8'b0, d});
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        cyc        = 0;
        last_fd    = 0;
        rst        = 1'b1;
        bus.enable   = 1'b0;
        bus.load     = 1'b0;
        bus.value    = 16'h0000;
        bus.dp_in    = 4'b0000;
        bus.blank_lz = 1'b0;

        // Reset state
        step_n(2);
        chk("rst_sel", {12'b0, bus.sel}, 16'h000F);
        chk("rst_data", {8'b0, bus.data}, 16'h00FF);
        chk("rst_fd", {15'b0, bus.frame_done}, 16'd0);

        // First edge after release
        rst        = 1'b0;
        bus.enable = 1'b1;
        step();
        chk_digit("first_edge", 4'b1110, 8'b0000_0011);

        // 1234 with no decimal points
        bus.load  = 1'b1;
        bus.value = 16'h1234;
        bus.dp_in = 4'b0000;
        step();
        bus.load = 1'b0;
        wait_frame();
        last_fd = cyc;
        step();
        chk("fd_one_cycle", {15'b0, bus.frame_done}, 16'd0);
        chk_digit("v1234_d0", 4'b1110, 8'b1001_1001);
        step_n(4);
        chk_digit("v1234_d1", 4'b1101, 8'b0000_1101);
        step_n(4);
        chk_digit("v1234_d2", 4'b1011, 8'b0010_0101);
        step_n(4);
        chk_digit("v1234_d3", 4'b0111, 8'b1001_1111);

        // ABCD, dp on digit 2, on both instances
        bus.load  = 1'b1;
        bus.value = 16'hABCD;
        bus.dp_in = 4'b0100;
        step();
        bus.load = 1'b0;
        wait_frame();
        chk("spacing16", 16'(cyc - last_fd), 16'd16);
        step();
        chk_digit("hex_d0", 4'b1110, 8'b1000_0101);
        chk("nohex_d0", {8'b0, bus_nh.data}, 16'h00FF);
        step_n(4);
        chk_digit("hex_d1", 4'b1101, 8'b0110_0011);
        chk("nohex_d1", {8'b0, bus_nh.data}, 16'h00FF);
        step_n(4);
        chk_digit("hex_d2", 4'b1011, 8'b1100_0000);
        chk("nohex_d2", {8'b0, bus_nh.data}, 16'h00FE);
        step_n(4);
        chk_digit("hex_d3", 4'b0111, 8'b0001_0001);
        chk("nohex_d3", {8'b0, bus_nh.data}, 16'h00FF);

        // Mid-frame load of 1111, then 2222 in the wrap cycle
        wait_frame();
        step_n(2);
        bus.load  = 1'b1;
        bus.value = 16'h1111;
        bus.dp_in = 4'b0000;
        step();
        bus.load = 1'b0;
        step_n(3);
        chk_digit("old_mid_frame", 4'b1101, 8'b0110_0011);
        step_n(9);
        bus.load  = 1'b1;
        bus.value = 16'h2222;
        step();
        bus.load = 1'b0;
        chk("wrap_fd", {15'b0, bus.frame_done}, 16'd1);
        step();
        chk_digit("f1111_d0", 4'b1110, 8'b1001_1111);
        step_n(4);
        chk_digit("f1111_d1", 4'b1101, 8'b1001_1111);
        step_n(11);
        chk("wrap2_fd", {15'b0, bus.frame_done}, 16'd1);
        last_fd = cyc;
        step();
        chk_digit("f2222_d0", 4'b1110, 8'b0010_0101);

        // Enable low for 10 cycles mid-digit; load still accepted while dark
        step();
        bus.enable = 1'b0;
        step();
        chk_digit("dark_start", 4'b1111, 8'hFF);
        step_n(5);
        bus.load  = 1'b1;
        bus.value = 16'h0050;
        step();
        bus.load = 1'b0;
        step_n(3);
        chk_digit("dark_end", 4'b1111, 8'hFF);
        bus.enable = 1'b1;
        step();
        chk_digit("resume", 4'b1110, 8'b0010_0101);
        wait_frame();
        chk("spacing26", 16'(cyc - last_fd), 16'd26);

        // Leading-zero blanking of 0050
        bus.blank_lz = 1'b1;
        step();
        chk_digit("blank_d0", 4'b1110, 8'b0000_0011);
        step_n(4);
        chk_digit("blank_d1", 4'b1101, 8'b0100_1001);
        step_n(4);
        chk_digit("blank_d2", 4'b1011, 8'hFF);
        step_n(4);
        chk_digit("blank_d3", 4'b0111, 8'hFF);

        // Asynchronous reset mid-cycle discards a pending load
        bus.load  = 1'b1;
        bus.value = 16'h1234;
        step();
        bus.load = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk_digit("async_rst", 4'b1111, 8'hFF);
        chk("async_rst_fd", {15'b0, bus.frame_done}, 16'd0);
        step();
        rst = 1'b0;
        step();
        chk_digit("post_rst_edge", 4'b1110, 8'b0000_0011);
        wait_frame();
        step();
        chk_digit("pending_dropped", 4'b1110, 8'b0000_0011);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
